dual_copy_read_ctrl: RTL and testbench



---
 rtl/dual_copy_read_ctrl.sv | 271 +++++++++++++++++++++++++++
 tb/tb_dual_copy_read_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_copy_read_ctrl.sv
// -----------------------------------------------------------------------------
// dual_copy_read_ctrl
//
// Read-path controller for a store that keeps two copies of every codeword.
// Each request reads the primary copy and sends it through the external ECC
// decoder. If the decoder flags an error, the same address is read from the
// secondary copy and decoded again. When the secondary copy decodes cleanly it
// is returned and, if REPAIR_EN is set, written back over the bad primary
// copy. One response is returned per request. Saturating counters track
// primary errors, repair writes and double failures.
//
// Ports
//   clk, rst        : clock (rising edge) and synchronous active-high reset
//   req_valid/ready : request handshake; ready only while idle
//   req_addr        : read address, captured on the accepting cycle
//   pri_rd_en       : primary read strobe (pri_rdata valid one cycle later)
//   pri_wr_en       : primary repair write strobe
//   pri_addr        : primary address for reads and repair writes
//   pri_wdata       : repair codeword (secondary copy), zero when not writing
//   pri_rdata       : primary read data
//   sec_rd_en       : secondary read strobe (sec_rdata valid one cycle later)
//   sec_addr        : secondary address
//   sec_rdata       : secondary read data
//   dec_en          : decoder strobe
//   dec_codeword    : codeword presented to the decoder, zero when idle
//   dec_data        : decoded data, valid one cycle after dec_en
//   dec_error       : decoder error flag, valid one cycle after dec_en
//   rsp_valid/ready : response handshake; response held until accepted
//   rsp_data        : returned data
//   rsp_source      : 0 = primary copy, 1 = secondary copy
//   rsp_fail        : both copies were flagged bad
//   rsp_repaired    : primary copy was rewritten for this request
//   cnt_pri_err     : saturating count of primary decode errors
//   cnt_repair      : saturating count of repair writes
//   cnt_fail        : saturating count of double failures
// -----------------------------------------------------------------------------
module dual_copy_read_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int CODEWORD_WIDTH = 16,
    parameter int ADDR_WIDTH     = 10,
    parameter int CNT_WIDTH      = 16,
    parameter bit REPAIR_EN      = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_WIDTH-1:0]     req_addr,

    output logic                      pri_rd_en,
    output logic                      pri_wr_en,
    output logic [ADDR_WIDTH-1:0]     pri_addr,
    output logic [CODEWORD_WIDTH-1:0] pri_wdata,
    input  logic [CODEWORD_WIDTH-1:0] pri_rdata,

    output logic                      sec_rd_en,
    output logic [ADDR_WIDTH-1:0]     sec_addr,
    input  logic [CODEWORD_WIDTH-1:0] sec_rdata,

    output logic                      dec_en,
    output logic [CODEWORD_WIDTH-1:0] dec_codeword,
    input  logic [DATA_WIDTH-1:0]     dec_data,
    input  logic                      dec_error,

    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_data,
    output logic                      rsp_source,
    output logic                      rsp_fail,
    output logic                      rsp_repaired,

    output logic [CNT_WIDTH-1:0]      cnt_pri_err,
    output logic [CNT_WIDTH-1:0]      cnt_repair,
    output logic [CNT_WIDTH-1:0]      cnt_fail
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_PRI_RD  = 4'd1,
        S_PRI_DEC = 4'd2,
        S_PRI_CHK = 4'd3,
        S_SEC_RD  = 4'd4,
        S_SEC_DEC = 4'd5,
        S_SEC_CHK = 4'd6,
        S_REPAIR  = 4'd7,
        S_RESP    = 4'd8
    } state_t;

    state_t                    r_state;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [CODEWORD_WIDTH-1:0] r_sec_cw;

    logic                      r_req_ready;
    logic                      r_pri_rd_en;
    logic                      r_pri_wr_en;
    logic                      r_sec_rd_en;
    logic                      r_dec_en;
    logic                      r_dec_sel_sec;

    logic                      r_rsp_valid;
    logic [DATA_WIDTH-1:0]     r_rsp_data;
    logic                      r_rsp_source;
    logic                      r_rsp_fail;
    logic                      r_rsp_repaired;

    logic [CNT_WIDTH-1:0]      r_cnt_pri_err;
    logic [CNT_WIDTH-1:0]      r_cnt_repair;
    logic [CNT_WIDTH-1:0]      r_cnt_fail;

    logic [CODEWORD_WIDTH-1:0] w_dec_codeword;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // The decoder sees the store read data directly in the cycle after the
    // read strobe, so the mux is combinational; it is forced to zero whenever
    // no decode is in progress.
    always_comb begin
        w_dec_codeword = '0;
        if (r_dec_en) begin
            w_dec_codeword = r_dec_sel_sec ? sec_rdata : pri_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_addr         <= '0;
            r_sec_cw       <= '0;
            r_req_ready    <= 1'b1;
            r_pri_rd_en    <= 1'b0;
            r_pri_wr_en    <= 1'b0;
            r_sec_rd_en    <= 1'b0;
            r_dec_en       <= 1'b0;
            r_dec_sel_sec  <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_data     <= '0;
            r_rsp_source   <= 1'b0;
            r_rsp_fail     <= 1'b0;
            r_rsp_repaired <= 1'b0;
            r_cnt_pri_err  <= '0;
            r_cnt_repair   <= '0;
            r_cnt_fail     <= '0;
        end else begin
            // Strobes are one-cycle pulses: each is raised only on the
            // transition into the state that owns it.
            r_pri_rd_en <= 1'b0;
            r_pri_wr_en <= 1'b0;
            r_sec_rd_en <= 1'b0;
            r_dec_en    <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_addr      <= req_addr;
                        r_req_ready <= 1'b0;
                        r_pri_rd_en <= 1'b1;
                        r_state     <= S_PRI_RD;
                    end
                end

                S_PRI_RD: begin
                    r_dec_en      <= 1'b1;
                    r_dec_sel_sec <= 1'b0;
                    r_state       <= S_PRI_DEC;
                end

                S_PRI_DEC: begin
                    r_state <= S_PRI_CHK;
                end

                S_PRI_CHK: begin
                    // Primary data is kept even when flagged, so a double
                    // failure can still return the best-effort primary value.
                    r_rsp_data   <= dec_data;
                    r_rsp_source <= 1'b0;
                    if (!dec_error) begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt_pri_err <= sat_inc(r_cnt_pri_err);
                        r_sec_rd_en   <= 1'b1;
                        r_state       <= S_SEC_RD;
                    end
                end

                S_SEC_RD: begin
                    r_dec_en      <= 1'b1;
                    r_dec_sel_sec <= 1'b1;
                    r_state       <= S_SEC_DEC;
                end

                S_SEC_DEC: begin
                    // Keep the raw secondary codeword for the repair write.
                    r_sec_cw <= sec_rdata;
                    r_state  <= S_SEC_CHK;
                end

                S_SEC_CHK: begin
                    if (!dec_error) begin
                        r_rsp_data   <= dec_data;
                        r_rsp_source <= 1'b1;
                        if (REPAIR_EN) begin
                            r_pri_wr_en    <= 1'b1;
                            r_rsp_repaired <= 1'b1;
                            r_cnt_repair   <= sat_inc(r_cnt_repair);
                            r_state        <= S_REPAIR;
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end
                    end else begin
                        r_rsp_fail   <= 1'b1;
                        r_rsp_source <= 1'b0;
                        r_cnt_fail   <= sat_inc(r_cnt_fail);
                        r_rsp_valid  <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end

                S_REPAIR: begin
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end

                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid    <= 1'b0;
                        r_rsp_data     <= '0;
                        r_rsp_source   <= 1'b0;
                        r_rsp_fail     <= 1'b0;
                        r_rsp_repaired <= 1'b0;
                        r_req_ready    <= 1'b1;
                        r_state        <= S_IDLE;
                    end
                end

                default: begin
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready    = r_req_ready;
    assign pri_rd_en    = r_pri_rd_en;
    assign pri_wr_en    = r_pri_wr_en;
    assign pri_addr     = r_addr;
    assign pri_wdata    = r_pri_wr_en ? r_sec_cw : '0;
    assign sec_rd_en    = r_sec_rd_en;
    assign sec_addr     = r_addr;
    assign dec_en       = r_dec_en;
    assign dec_codeword = w_dec_codeword;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;
    assign rsp_source   = r_rsp_source;
    assign rsp_fail     = r_rsp_fail;
    assign rsp_repaired = r_rsp_repaired;
    assign cnt_pri_err  = r_cnt_pri_err;
    assign cnt_repair   = r_cnt_repair;
    assign cnt_fail     = r_cnt_fail;

endmodule

// File: tb/tb_dual_copy_read_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for dual_copy_read_ctrl. Instance 0 uses default parameters; instance
// 1 has repair disabled and 2-bit counters so saturation is reachable quickly.
// Each instance has its own primary/secondary store model and a decoder model
// where data = codeword[7:0] and error = odd parity of codeword[15:8].
// -----------------------------------------------------------------------------
module tb_dual_copy_read_ctrl;

    logic clk;
    logic rst;

    logic        req_valid    [2];
    logic        req_ready    [2];
    logic [9:0]  req_addr     [2];
    logic        pri_rd_en    [2];
    logic        pri_wr_en    [2];
    logic [9:0]  pri_addr     [2];
    logic [15:0] pri_wdata    [2];
    logic [15:0] pri_rdata    [2];
    logic        sec_rd_en    [2];
    logic [9:0]  sec_addr     [2];
    logic [15:0] sec_rdata    [2];
    logic        dec_en       [2];
    logic [15:0] dec_codeword [2];
    logic [7:0]  dec_data     [2];
    logic        dec_error    [2];
    logic        rsp_valid    [2];
    logic        rsp_ready    [2];
    logic [7:0]  rsp_data     [2];
    logic        rsp_source   [2];
    logic        rsp_fail     [2];
    logic        rsp_repaired [2];

    logic [15:0] cnt_pri_err0, cnt_repair0, cnt_fail0;
    logic [1:0]  cnt_pri_err1, cnt_repair1, cnt_fail1;

    logic [15:0] pmem [2][1024];
    logic [15:0] smem [2][1024];

    logic        ld_en;
    logic        ld_sec;
    int          ld_k;
    logic [9:0]  ld_addr;
    logic [15:0] ld_data;

    int n_checks = 0;
    int n_fail   = 0;

    dual_copy_read_ctrl dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .pri_rd_en(pri_rd_en[0]), .pri_wr_en(pri_wr_en[0]), .pri_addr(pri_addr[0]),
        .pri_wdata(pri_wdata[0]), .pri_rdata(pri_rdata[0]),
        .sec_rd_en(sec_rd_en[0]), .sec_addr(sec_addr[0]), .sec_rdata(sec_rdata[0]),
        .dec_en(dec_en[0]), .dec_codeword(dec_codeword[0]),
        .dec_data(dec_data[0]), .dec_error(dec_error[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
        .rsp_source(rsp_source[0]), .rsp_fail(rsp_fail[0]), .rsp_repaired(rsp_repaired[0]),
        .cnt_pri_err(cnt_pri_err0), .cnt_repair(cnt_repair0), .cnt_fail(cnt_fail0)
    );

    dual_copy_read_ctrl #(
        .CNT_WIDTH(2),
        .REPAIR_EN(1'b0)
    ) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .pri_rd_en(pri_rd_en[1]), .pri_wr_en(pri_wr_en[1]), .pri_addr(pri_addr[1]),
        .pri_wdata(pri_wdata[1]), .pri_rdata(pri_rdata[1]),
        .sec_rd_en(sec_rd_en[1]), .sec_addr(sec_addr[1]), .sec_rdata(sec_rdata[1]),
        .dec_en(dec_en[1]), .dec_codeword(dec_codeword[1]),
        .dec_data(dec_data[1]), .dec_error(dec_error[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
        .rsp_source(rsp_source[1]), .rsp_fail(rsp_fail[1]), .rsp_repaired(rsp_repaired[1]),
        .cnt_pri_err(cnt_pri_err1), .cnt_repair(cnt_repair1), .cnt_fail(cnt_fail1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Store and decoder models, plus the preload port.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (pri_rd_en[k]) pri_rdata[k] <= pmem[k][pri_addr[k]];
            if (pri_wr_en[k]) pmem[k][pri_addr[k]] <= pri_wdata[k];
            if (sec_rd_en[k]) sec_rdata[k] <= smem[k][sec_addr[k]];
            if (dec_en[k]) begin
                dec_data[k]  <= dec_codeword[k][7:0];
                dec_error[k] <= ^dec_codeword[k][15:8];
            end
        end
        if (ld_en) begin
            if (ld_sec) smem[ld_k][ld_addr] <= ld_data;
            else        pmem[ld_k][ld_addr] <= ld_data;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] cnt_of(input int k, input int which);
        if (k == 0) begin
            case (which)
                0:       return 32'(cnt_pri_err0);
                1:       return 32'(cnt_repair0);
                default: return 32'(cnt_fail0);
            endcase
        end
        case (which)
            0:       return 32'(cnt_pri_err1);
            1:       return 32'(cnt_repair1);
            default: return 32'(cnt_fail1);
        endcase
    endfunction

    task automatic check_cnts(input string tag, input int k, input int e_err, input int e_rep, input int e_fail);
        check_val({tag, "_cnt_pri_err"}, cnt_of(k, 0), 32'(e_err));
        check_val({tag, "_cnt_repair"},  cnt_of(k, 1), 32'(e_rep));
        check_val({tag, "_cnt_fail"},    cnt_of(k, 2), 32'(e_fail));
    endtask

    task automatic load(input int k, input logic sec, input logic [9:0] addr, input logic [15:0] data);
        @(negedge clk);
        ld_en = 1'b1; ld_k = k; ld_sec = sec; ld_addr = addr; ld_data = data;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Issue one request and follow it to its response. Latency is counted in
    // cycles after the accepting cycle; exp_wr_cyc = 0 means no repair write.
    task automatic do_req(input string tag, input int k, input logic [9:0] addr,
                          input int exp_lat, input logic [7:0] exp_data,
                          input logic exp_src, input logic exp_fail, input logic exp_rep,
                          input int exp_wr_cyc, input logic [15:0] exp_wdata, input int hold);
        int n = 0, prd = 0, srd = 0, wr = 0, wr_cyc = 0, both = 0;
        logic [15:0] wd = '0;
        logic got = 1'b0;
        @(negedge clk);
        check_val({tag, "_req_ready_idle"}, 32'(req_ready[k]), 32'd1);
        req_valid[k] = 1'b1;
        req_addr[k]  = addr;
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
        req_addr[k]  = '0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (pri_rd_en[k]) prd++;
            if (sec_rd_en[k]) srd++;
            if (pri_wr_en[k]) begin
                wr++;
                wr_cyc = n;
                wd = pri_wdata[k];
            end
            if (pri_rd_en[k] && pri_wr_en[k]) both++;
            if (rsp_valid[k]) got = 1'b1;
        end
        check_val({tag, "_rsp_seen"}, 32'(got), 32'd1);
        if (!got) return;
        check_val({tag, "_latency"},  32'(n), 32'(exp_lat));
        check_val({tag, "_data"},     32'(rsp_data[k]), 32'(exp_data));
        check_val({tag, "_source"},   32'(rsp_source[k]), 32'(exp_src));
        check_val({tag, "_fail"},     32'(rsp_fail[k]), 32'(exp_fail));
        check_val({tag, "_repaired"}, 32'(rsp_repaired[k]), 32'(exp_rep));
        check_val({tag, "_pri_rd_cnt"}, 32'(prd), 32'd1);
        check_val({tag, "_sec_rd_cnt"}, 32'(srd), (exp_lat == 4) ? 32'd0 : 32'd1);
        check_val({tag, "_wr_cnt"},   32'(wr), (exp_wr_cyc > 0) ? 32'd1 : 32'd0);
        if (exp_wr_cyc > 0) begin
            check_val({tag, "_wr_cycle"}, 32'(wr_cyc), 32'(exp_wr_cyc));
            check_val({tag, "_wdata"},    32'(wd), 32'(exp_wdata));
        end
        check_val({tag, "_rd_wr_overlap"}, 32'(both), 32'd0);
        check_val({tag, "_req_ready_busy"}, 32'(req_ready[k]), 32'd0);
        for (int h = 0; h < hold; h++) begin
            req_valid[k] = 1'b1;
            req_addr[k]  = 10'd5;
            @(negedge clk);
            check_val({tag, "_hold_valid"}, 32'(rsp_valid[k]), 32'd1);
            check_val({tag, "_hold_data"},  32'(rsp_data[k]), 32'(exp_data));
            check_val({tag, "_hold_ready"}, 32'(req_ready[k]), 32'd0);
            check_val({tag, "_hold_no_rd"}, 32'(pri_rd_en[k]), 32'd0);
        end
        req_valid[k] = 1'b0;
        req_addr[k]  = '0;
        rsp_ready[k] = 1'b1;
        @(negedge clk);
        rsp_ready[k] = 1'b0;
        check_val({tag, "_rsp_cleared"}, 32'(rsp_valid[k]), 32'd0);
        check_val({tag, "_back_idle"},   32'(req_ready[k]), 32'd1);
        @(negedge clk);
        check_val({tag, "_no_new_rd"},   32'(pri_rd_en[k]), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        ld_en  = 1'b0; ld_sec = 1'b0; ld_k = 0; ld_addr = '0; ld_data = '0;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0;
            req_addr[k]  = '0;
            rsp_ready[k] = 1'b0;
        end

        // Reset state, with rsp_ready held high to show it has no effect.
        repeat (3) @(negedge clk);
        rsp_ready[0] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            check_val("rst_req_ready", 32'(req_ready[k]), 32'd1);
            check_val("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
            check_val("rst_strobes", 32'({pri_rd_en[k], pri_wr_en[k], sec_rd_en[k], dec_en[k]}), 32'd0);
            check_val("rst_dec_cw", 32'(dec_codeword[k]), 32'd0);
            check_val("rst_rsp_flags", 32'({rsp_data[k], rsp_source[k], rsp_fail[k], rsp_repaired[k]}), 32'd0);
            check_cnts("rst", k, 0, 0, 0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_val("idle_rsp_ready_no_effect", 32'(rsp_valid[0]), 32'd0);
        check_val("idle_ready_kept", 32'(req_ready[0]), 32'd1);
        rsp_ready[0] = 1'b0;

        load(0, 1'b0, 10'd3, 16'h00A5);
        load(0, 1'b0, 10'd7, 16'h01A5);
        load(0, 1'b1, 10'd7, 16'h5501);
        load(0, 1'b0, 10'd2, 16'h01A5);
        load(0, 1'b1, 10'd2, 16'h01A5);
        load(0, 1'b0, 10'd9, 16'h01A5);
        load(0, 1'b1, 10'd9, 16'h5501);
        load(1, 1'b0, 10'd7, 16'h01A5);
        load(1, 1'b1, 10'd7, 16'h5501);

        // Clean primary.
        do_req("s1", 0, 10'd3, 4, 8'hA5, 1'b0, 1'b0, 1'b0, 0, 16'h0, 0);
        check_cnts("s1", 0, 0, 0, 0);

        // Primary bad, secondary clean, repair.
        do_req("s2", 0, 10'd7, 8, 8'h01, 1'b1, 1'b0, 1'b1, 7, 16'h5501, 0);
        check_cnts("s2", 0, 1, 1, 0);
        check_val("s2_pmem_repaired", 32'(pmem[0][7]), 32'h5501);
        do_req("s2_reread", 0, 10'd7, 4, 8'h01, 1'b0, 1'b0, 1'b0, 0, 16'h0, 0);
        check_cnts("s2_reread", 0, 1, 1, 0);

        // Double failure returns the primary data.
        do_req("s3", 0, 10'd2, 7, 8'hA5, 1'b0, 1'b1, 1'b0, 0, 16'h0, 0);
        check_cnts("s3", 0, 2, 1, 1);

        // Response back-pressure for 5 cycles with a competing request.
        do_req("s5", 0, 10'd3, 4, 8'hA5, 1'b0, 1'b0, 1'b0, 0, 16'h0, 5);
        check_cnts("s5", 0, 2, 1, 1);

        // Repair disabled; then saturate the 2-bit error counter.
        do_req("s4", 1, 10'd7, 7, 8'h01, 1'b1, 1'b0, 1'b0, 0, 16'h0, 0);
        check_cnts("s4", 1, 1, 0, 0);
        check_val("s4_pmem_untouched", 32'(pmem[1][7]), 32'h01A5);
        do_req("sat_a", 1, 10'd7, 7, 8'h01, 1'b1, 1'b0, 1'b0, 0, 16'h0, 0);
        do_req("sat_b", 1, 10'd7, 7, 8'h01, 1'b1, 1'b0, 1'b0, 0, 16'h0, 0);
        check_cnts("sat_b", 1, 3, 0, 0);
        do_req("sat_c", 1, 10'd7, 7, 8'h01, 1'b1, 1'b0, 1'b0, 0, 16'h0, 0);
        check_cnts("sat_c", 1, 3, 0, 0);

        // Reset while in SEC_DEC: no repair write may follow.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_addr[0]  = 10'd9;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        req_addr[0]  = '0;
        repeat (5) @(negedge clk);
        check_val("s6_in_sec_dec", 32'({dec_en[0], dec_codeword[0]}), 32'h15501);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("s6_req_ready", 32'(req_ready[0]), 32'd1);
        check_val("s6_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check_val("s6_strobes", 32'({pri_rd_en[0], pri_wr_en[0], sec_rd_en[0], dec_en[0]}), 32'd0);
        check_val("s6_rsp_flags", 32'({rsp_data[0], rsp_source[0], rsp_fail[0], rsp_repaired[0]}), 32'd0);
        check_cnts("s6", 0, 0, 0, 0);
        check_cnts("s6_inst1", 1, 0, 0, 0);
        begin
            int wr = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (pri_wr_en[0]) wr++;
            end
            check_val("s6_no_wr", 32'(wr), 32'd0);
        end
        check_val("s6_pmem_untouched", 32'(pmem[0][9]), 32'h01A5);
        check_val("s6_idle_after", 32'(req_ready[0]), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
